handshake_const_rr_arbiter: RTL and testbench
=============================================

Name: handshake_const_rr_arbiter

Overview:
- Shares one coefficient/constant table between NUM_REQ elastic requester channels in the Dynamatic-generated softclip datapath.
- Each requester presents a table index; the block grants one requester per cycle, round-robin.
- The selected constant and the winning requester ID go into a single registered output slot.
- Replaces per-site constant sources where several consumers need the same coefficient set.

Parameters:
- NUM_REQ, 4: number of requester channels (2..8).
- DATA_WIDTH, 13: constant width.
- IDX_WIDTH, 3: table index width.
- TABLE_DEPTH, 8: valid table entries (<= 2**IDX_WIDTH).
- TABLE_INIT, {7{13'h0}, 13'h0FAE}: flattened table, entry k at bits [k*DATA_WIDTH +: DATA_WIDTH]; entry 0 = 13'b0111110101110.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ins_idx  in  NUM_REQ*IDX_WIDTH  requester i index at [i*IDX_WIDTH +: IDX_WIDTH].
- ins_valid  in  NUM_REQ  per-requester valid.
- ins_ready  out  NUM_REQ  per-requester ready (one-hot grant or zero).
- outs  out  DATA_WIDTH  selected constant.
- outs_id  out  clog2(NUM_REQ)  index of granted requester.
- outs_valid  out  1  output slot full.
- outs_ready  in  1  consumer ready.

Behaviour:
- Reset (rst=0, asynchronous): outs_valid=0, outs=0, outs_id=0, rr pointer=0, ins_ready=0. Release is synchronous to clk.
- Slot may load when: can_load = !outs_valid || outs_ready.
- Arbitration is combinational.
  - Search ins_valid starting at the pointer, wrapping modulo NUM_REQ; the first asserted bit wins.
  - ins_ready[w]=1 only if can_load, else all zero.
  - ins_ready must not depend on ins_valid of other requesters beyond the priority search (no ready-to-valid loop on the winner's own valid).
- Transfer on requester w = ins_valid[w] && ins_ready[w]. At the next edge:
  - outs = TABLE[ins_idx_w], outs_id = w, outs_valid = 1.
  - pointer = (w+1) mod NUM_REQ.
- Latency: 1 cycle from accepted request to outs_valid.
- Throughput: 1 per cycle while outs_ready=1.
- Drain: outs_valid && outs_ready with no new grant gives outs_valid=0 next cycle. outs and outs_id hold their last value.
- Simultaneous drain and load: the slot is overwritten and outs_valid stays 1. No bubble.
- Backpressure: outs_valid=1 and outs_ready=0 give all ins_ready=0; outs, outs_id and the pointer are held stable.
- Pointer advances only on a transfer. An idle cycle leaves it unchanged.
- Out-of-range index (ins_idx >= TABLE_DEPTH): the request is accepted normally and outs = 0.
- NUM_REQ=1 degenerates to a registered constant lookup; outs_id is 1 bit and always 0.
- Reset mid-transaction: the pending output is discarded and no handshake completes in the reset cycle.

Optional Feature:
- Macro: CONST_ARB_STATS_EN.
- Defined: adds output grant_cnt (32 bits) and output stall_cnt (32 bits), both reset to 0.
  - grant_cnt increments on every input transfer.
  - stall_cnt increments each cycle outs_valid && !outs_ready.
  - Both wrap modulo 2**32.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package holds:
  - a localparam function clog2 used for the outs_id width;
  - a constant for the default softclip coefficient (13'h0FAE).
- Natural sub-module: rr_priority_pick (NUM_REQ). Inputs are the request vector and pointer; outputs are a one-hot grant and a binary index. It is purely combinational and reusable by other Dynamatic arbiters.
- Table lookup and the output register stay in the top.

Test Plan:
- Reset then idle: rst low for 3 cycles with all ins_valid=0 -> outs_valid=0, ins_ready=0, outs=0.
- Single request: ins_valid=4'b0001, idx0=0, outs_ready=1 -> next cycle outs=13'h0FAE, outs_id=0, outs_valid=1; pointer becomes 1.
- Fairness: all four valid continuously, outs_ready=1, 8 cycles -> outs_id sequence 0,1,2,3,0,1,2,3; each requester sees exactly 2 grants.
- Backpressure: outs_valid=1, outs_ready=0 for 5 cycles with requests pending -> ins_ready=0 and outs stable. outs_ready=1 -> the next grant loads in the same cycle as the drain, with no gap.
- Out-of-range index: TABLE_DEPTH=6, idx=7 from requester 2 -> outs=0, outs_id=2, accepted in 1 cycle.
- Stats (macro defined): 10 transfers with 3 stall cycles -> grant_cnt=10, stall_cnt=3. Asserting rst mid-run clears both counters and outs_valid asynchronously.

Source files
------------

// File: rtl/handshake_const_rr_arbiter_pkg.sv
// Shared definitions for the constant-table round-robin arbiter:
// width helpers and the default softclip coefficient.
package handshake_const_rr_arbiter_pkg;

   localparam logic [12:0] SOFTCLIP_COEFF = 13'h0FAE;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic int id_width(input int n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/handshake_const_rr_arbiter_if.sv
// Requester and consumer handshake bundle of the constant-table arbiter.
// slave: the arbiter side; master: the requesters plus the consumer.
interface handshake_const_rr_arbiter_if
   import handshake_const_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 13,
   parameter int IDX_WIDTH  = 3
);
   localparam int ID_WIDTH = id_width(NUM_REQ);

   logic [NUM_REQ*IDX_WIDTH-1:0] ins_idx;
   logic [NUM_REQ-1:0]           ins_valid;
   logic [NUM_REQ-1:0]           ins_ready;
   logic [DATA_WIDTH-1:0]        outs;
   logic [ID_WIDTH-1:0]          outs_id;
   logic                         outs_valid;
   logic                         outs_ready;

   modport slave (
      input  ins_idx, ins_valid, outs_ready,
      output ins_ready, outs, outs_id, outs_valid
   );

   modport master (
      output ins_idx, ins_valid, outs_ready,
      input  ins_ready, outs, outs_id, outs_valid
   );

endinterface

// File: rtl/handshake_const_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin priority picker: scans the request vector
// starting at ptr, wrapping around, and reports the first asserted bit
// as a one-hot grant plus its binary index.
module rr_priority_pick
   import handshake_const_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]               req,
   input  logic [id_width(NUM_REQ)-1:0]     ptr,
   output logic [NUM_REQ-1:0]               grant,
   output logic [id_width(NUM_REQ)-1:0]     idx,
   output logic                             any
);
   localparam int ID_WIDTH = id_width(NUM_REQ);

   // First asserted request at or after the pointer, modulo NUM_REQ.
   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         c = (int'(ptr) + k) % NUM_REQ;
         if (!any && req[c]) begin
            any      = 1'b1;
            grant[c] = 1'b1;
            idx      = ID_WIDTH'(c);
         end
      end
   end

endmodule

// File: rtl/handshake_const_rr_arbiter.sv
// Round-robin arbiter sharing one constant table between NUM_REQ elastic
// requesters. The winner's table entry and ID land in a single output
// slot that can be drained and reloaded in the same cycle.
// Optional statistics counters: define CONST_ARB_STATS_EN.
module handshake_const_rr_arbiter
   import handshake_const_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 13,
   parameter int IDX_WIDTH   = 3,
   parameter int TABLE_DEPTH = 8,
   parameter logic [DATA_WIDTH*(1<<IDX_WIDTH)-1:0] TABLE_INIT =
      {{((1<<IDX_WIDTH)-1){DATA_WIDTH'(0)}}, DATA_WIDTH'(SOFTCLIP_COEFF)}
) (
   input  logic clk,
   input  logic rst,
   handshake_const_rr_arbiter_if.slave bus
`ifdef CONST_ARB_STATS_EN
   ,
   output logic [31:0] grant_cnt,
   output logic [31:0] stall_cnt
`endif
);
   localparam int ID_WIDTH = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]    grant;
   logic [ID_WIDTH-1:0]   win;
   logic [ID_WIDTH-1:0]   ptr;
   logic [ID_WIDTH-1:0]   ptr_next;
   logic                  any_req;
   logic                  can_load;
   logic                  xfer;
   logic [IDX_WIDTH-1:0]  win_idx;
   logic [DATA_WIDTH-1:0] lookup;
   logic [DATA_WIDTH-1:0] outs_q;
   logic [ID_WIDTH-1:0]   outs_id_q;
   logic                  outs_valid_q;

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req   (bus.ins_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (win),
      .any   (any_req)
   );

   assign can_load = !outs_valid_q || bus.outs_ready;

   assign bus.ins_ready = (can_load && rst) ? grant : '0;

   assign xfer = any_req && can_load && rst;

   // Winner's index, its table entry (zero when past TABLE_DEPTH) and the next pointer.
   always_comb begin
      win_idx = bus.ins_idx[int'(win)*IDX_WIDTH +: IDX_WIDTH];
      lookup  = '0;
      if (int'(win_idx) < TABLE_DEPTH) begin
         lookup = TABLE_INIT[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      ptr_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
   end

   // Output slot and pointer: load on a transfer, otherwise drain when consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outs_q       <= '0;
         outs_id_q    <= '0;
         outs_valid_q <= 1'b0;
         ptr          <= '0;
      end else if (xfer) begin
         outs_q       <= lookup;
         outs_id_q    <= win;
         outs_valid_q <= 1'b1;
         ptr          <= ptr_next;
      end else if (bus.outs_ready) begin
         outs_valid_q <= 1'b0;
      end
   end

   assign bus.outs       = outs_q;
   assign bus.outs_id    = outs_id_q;
   assign bus.outs_valid = outs_valid_q;

`ifdef CONST_ARB_STATS_EN
   // Wrapping counters of accepted requests and backpressured output cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (xfer) begin
            grant_cnt <= grant_cnt + 32'd1;
         end
         if (outs_valid_q && !bus.outs_ready) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_handshake_const_rr_arbiter.sv
// Self-checking bench for handshake_const_rr_arbiter: directed vectors push
// expected output slots into a queue that a negedge monitor pops on each
// consumed output. Stats checks are active when CONST_ARB_STATS_EN is defined.
module tb_handshake_const_rr_arbiter;

   typedef struct {
      logic [12:0] data;
      logic [1:0]  id;
   } exp_t;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;
   exp_t sbq[$];
   int   grantTally[4];

   logic [12:0] fairData[4];

`ifdef CONST_ARB_STATS_EN
   logic [31:0] grant_cnt;
   logic [31:0] stall_cnt;
`endif

   handshake_const_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(13), .IDX_WIDTH(3)) bus ();

   handshake_const_rr_arbiter #(
      .NUM_REQ     (4),
      .DATA_WIDTH  (13),
      .IDX_WIDTH   (3),
      .TABLE_DEPTH (6),
      .TABLE_INIT  ({13'h1777, 13'h1666, 13'h0505, 13'h0404,
                     13'h0303, 13'h0202, 13'h0101, 13'h0FAE})
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef CONST_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs just after the clock edge, optionally queue the
   // output slot that the coming edge should load, then wait for the sample point.
   task automatic applyStimulus(input logic [3:0] v, input logic [11:0] idx, input logic ordy,
                                input logic push, input logic [12:0] expData, input logic [1:0] expId);
      exp_t e;
      @(posedge clk);
      #1;
      bus.ins_valid  = v;
      bus.ins_idx    = idx;
      bus.outs_ready = ordy;
      if (push) begin
         e.data = expData;
         e.id   = expId;
         sbq.push_back(e);
      end
      @(negedge clk);
   endtask

   // Monitor: every consumed output slot must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && bus.outs_valid && bus.outs_ready) begin
            if (sbq.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_output: got data 0x%0h id %0d, expected none", bus.outs, bus.outs_id);
            end else begin
               e = sbq.pop_front();
               checkOutput("sb_data", 32'(bus.outs), 32'(e.data));
               checkOutput("sb_id", 32'(bus.outs_id), 32'(e.id));
            end
         end
      end
   end

   initial begin
      fairData[0] = 13'h0101;
      fairData[1] = 13'h0202;
      fairData[2] = 13'h0404;
      fairData[3] = 13'h0505;
      testsRun    = 0;
      testsFailed = 0;
      rst            = 1'b0;
      bus.ins_valid  = '0;
      bus.ins_idx    = '0;
      bus.outs_ready = 1'b0;

      // Reset, idle: three cycles held low, last one with all requests raised.
      repeat (2) @(negedge clk);
      checkOutput("rst_outs_valid", 32'(bus.outs_valid), 32'd0);
      checkOutput("rst_outs", 32'(bus.outs), 32'd0);
      checkOutput("rst_outs_id", 32'(bus.outs_id), 32'd0);
      applyStimulus(4'b1111, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      checkOutput("rst_ins_ready", 32'(bus.ins_ready), 32'd0);
      @(posedge clk);
      #1;
      rst            = 1'b1;
      bus.ins_valid  = '0;
      bus.outs_ready = 1'b0;
      @(negedge clk);
      checkOutput("idle_outs_valid", 32'(bus.outs_valid), 32'd0);
      checkOutput("idle_ins_ready", 32'(bus.ins_ready), 32'd0);

      // Single request from requester 0, index 0.
      applyStimulus(4'b0001, 12'h000, 1'b1, 1'b1, 13'h0FAE, 2'd0);
      checkOutput("single_ready", 32'(bus.ins_ready), 32'b0001);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      checkOutput("single_latency_valid", 32'(bus.outs_valid), 32'd1);
      checkOutput("single_latency_outs", 32'(bus.outs), 32'h0FAE);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      checkOutput("drain_valid", 32'(bus.outs_valid), 32'd0);
      checkOutput("drain_outs_hold", 32'(bus.outs), 32'h0FAE);

      // Pointer now 1: requesters 0 and 3 pending, 3 must win.
      applyStimulus(4'b1001, 12'h600, 1'b1, 1'b1, 13'h0303, 2'd3);
      checkOutput("ptr_ready", 32'(bus.ins_ready), 32'b1000);

      // Fairness: all four pending for eight cycles, pointer back at 0.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'b1111, 12'hB11, 1'b1, 1'b1, fairData[i % 4], 2'(i % 4));
         checkOutput("fair_ready", 32'(bus.ins_ready), 32'(4'b0001 << (i % 4)));
         for (int r = 0; r < 4; r++) begin
            if (bus.ins_ready[r]) grantTally[r]++;
         end
      end
      for (int r = 0; r < 4; r++) begin
         checkOutput("fair_tally", 32'(grantTally[r]), 32'd2);
      end

      // Backpressure: slot holds requester 3's entry, nothing accepted.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 12'hB11, 1'b0, 1'b0, 13'h0, 2'd0);
         checkOutput("bp_ready", 32'(bus.ins_ready), 32'd0);
         checkOutput("bp_outs", 32'(bus.outs), 32'h0505);
         checkOutput("bp_outs_id", 32'(bus.outs_id), 32'd3);
      end
      applyStimulus(4'b1111, 12'hB11, 1'b1, 1'b1, 13'h0101, 2'd0);
      checkOutput("bp_release_ready", 32'(bus.ins_ready), 32'b0001);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      checkOutput("bp_nogap_valid", 32'(bus.outs_valid), 32'd1);
      checkOutput("bp_nogap_id", 32'(bus.outs_id), 32'd0);

      // Table boundary: indices 7 and 6 are out of range, 5 is the last entry.
      applyStimulus(4'b0100, 12'h1C0, 1'b1, 1'b1, 13'h0000, 2'd2);
      checkOutput("oor7_ready", 32'(bus.ins_ready), 32'b0100);
      applyStimulus(4'b0100, 12'h180, 1'b1, 1'b1, 13'h0000, 2'd2);
      applyStimulus(4'b0100, 12'h140, 1'b1, 1'b1, 13'h0505, 2'd2);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      checkOutput("queue_drained", 32'(sbq.size()), 32'd0);
`ifdef CONST_ARB_STATS_EN
      checkOutput("stats_grant_cnt", grant_cnt, 32'd14);
      checkOutput("stats_stall_cnt", stall_cnt, 32'd5);
`endif

      // Reset mid-transaction: a loaded, stalled slot is discarded asynchronously.
      applyStimulus(4'b0001, 12'h000, 1'b0, 1'b0, 13'h0, 2'd0);
      applyStimulus(4'b0001, 12'h000, 1'b0, 1'b0, 13'h0, 2'd0);
      checkOutput("midrst_pre_valid", 32'(bus.outs_valid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midrst_outs_valid", 32'(bus.outs_valid), 32'd0);
      checkOutput("midrst_outs", 32'(bus.outs), 32'd0);
      checkOutput("midrst_ins_ready", 32'(bus.ins_ready), 32'd0);
`ifdef CONST_ARB_STATS_EN
      checkOutput("midrst_grant_cnt", grant_cnt, 32'd0);
      checkOutput("midrst_stall_cnt", stall_cnt, 32'd0);
`endif
      sbq.delete();
      @(posedge clk);
      #1;
      bus.ins_valid = '0;
      rst           = 1'b1;

      // After reset the pointer is 0 again: requesters 1 and 3 pending, 1 wins.
      applyStimulus(4'b1010, 12'h010, 1'b1, 1'b1, 13'h0202, 2'd1);
      checkOutput("post_rst_ready", 32'(bus.ins_ready), 32'b0010);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      applyStimulus(4'b0000, 12'h000, 1'b1, 1'b0, 13'h0, 2'd0);
      checkOutput("final_queue_drained", 32'(sbq.size()), 32'd0);
`ifdef CONST_ARB_STATS_EN
      checkOutput("final_grant_cnt", grant_cnt, 32'd1);
      checkOutput("final_stall_cnt", stall_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
